ula_stage: RTL and testbench
============================

# ula_stage

Registered issue/retire stage wrapped around the combinational `ula`. It accepts ALU operations over a valid/ready handshake and buffers them in a small FIFO. The FIFO head drives `ula`'s `func`/`ulaA`/`ulaB` inputs; the stage captures `ula`'s result and flags into an output register with its own valid/ready handshake. It also normalizes flags per opcode, keeps a last-retired status register and an operation counter.

## Interface
Parameters:
- `DEPTH`, default 2: input FIFO entries. Power of two, 2..8.
- `TAGW`, default 4: width of the opaque tag carried with each operation.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `inValid`  in  1  upstream offers an operation.
- `inReady`  out  1  stage can accept an operation.
- `inFunc`  in  3  opcode: LOADA=000, ADD=001, SUB=010, AND=011, PLUS1=100, NOT=101, XOR=110, COMP=111.
- `inA`, `inB`  in  32  operands.
- `inTag`  in  TAGW  tag, returned unchanged with the result.
- `func`  out  3  to `ula`.
- `ulaA`, `ulaB`  out  32  to `ula`.
- `ulaOutput`  in  32  from `ula`.
- `ulaZ`, `ulaN`, `ulaO`, `ulaET`, `ulaGT`, `ulaLT`  in  1 each  from `ula`.
- `outValid`  out  1  result register holds a result.
- `outReady`  in  1  downstream accepts the result.
- `outResult`  out  32  registered result.
- `outFlags`  out  6  registered normalized flags {Z,N,O,ET,GT,LT}, bit 5 = Z.
- `outTag`  out  TAGW  tag of the result.
- `statusFlags`  out  6  flags of the most recently captured operation.
- `opCount`  out  16  number of captured operations, modulo 2^16.

## Operation
- Push: on `inValid && inReady`, write {inFunc,inA,inB,inTag} at the FIFO tail.
- `inReady = rst_n && (count < DEPTH)`. It does not depend on `outReady`.
- FIFO head drives `func`/`ulaA`/`ulaB` combinationally.
- When the FIFO is empty, drive `func`=000, `ulaA`=0, `ulaB`=0.
- Capture condition: `capture = headValid && (!outValid || outReady)`.
- On capture, in one edge:
  - pop the head;
  - load the output register;
  - set `outValid`=1;
  - load `statusFlags` with the same normalized flags;
  - increment `opCount` (wraps 0xFFFF→0x0000).
- On `outValid && outReady && !capture`: clear `outValid`. `outResult`/`outFlags`/`outTag` hold their values.
- Flag normalization (required because `ula` holds stale values for flags and results not produced by the current opcode):
  - Non-COMP opcodes:
    - `outResult = ulaOutput`.
    - Z = (`ulaOutput`==0); N = `ulaOutput[31]`.
    - ET = GT = LT = 0.
    - O = `ulaO` only for ADD/SUB, else 0.
  - COMP:
    - `outResult` = 0; Z = N = O = 0.
    - ET/GT/LT taken from `ula`. Exactly one is 1; comparison is unsigned.
- Push and pop in the same cycle are allowed at any occupancy below full; count is unchanged.
- At full, no push occurs (`inReady`=0) even if a pop happens that cycle.

## Timing
- Reset: while `rst_n`=0 at an edge, the following clear, regardless of handshakes in that cycle:
  - FIFO (count=0), `outValid`, `outResult`, `outFlags`, `outTag`, `statusFlags`, `opCount`.
- After reset, `inReady` is 1 from the first cycle with `rst_n`=1.
- Reset mid-operation discards all buffered and pending results; nothing is replayed.
- Latency: accepted at edge N → drives `ula` during cycle N+1 → `outValid`=1 after edge N+1 (2 edges), provided the output register is free.
- Throughput: one operation per cycle with `outReady` held high.
- Backpressure: with `outReady`=0 and `outValid`=1, the head is held and `ula` inputs stay stable. The FIFO fills, and `inReady` drops after DEPTH further pushes.
- Outputs toward downstream (`outValid`, `outResult`, `outFlags`, `outTag`) are registered. Outputs toward `ula` are combinational from FIFO state.

## Test plan
- Reset then ADD A=0x7FFFFFFF, B=1, tag 3 → 2 edges later `outValid`=1, `outResult`=0x80000000, `outFlags`=010000 | 001000 (N=1, O=1), `outTag`=3, `opCount`=1.
- COMP A=5, B=9 immediately after a SUB 5−5 → `outResult`=0, `outFlags`=000001 (LT only). The preceding SUB shows `outFlags`=100000 (Z only). No stale O/Z on COMP.
- `outReady`=0, push DEPTH+1 ops with `inValid` held → first result held; `inReady`=0 after DEPTH queued. Release `outReady` → results in order, one per cycle, tags intact.
- Back-to-back stream of 8 PLUS1 ops with A=0xFFFFFFFF..., `outReady`=1 → 8 results on 8 consecutive cycles; PLUS1 of 0xFFFFFFFF gives result 0, Z=1, O=0.
- Assert `rst_n`=0 for one cycle with 2 ops queued and `outValid`=1 → next cycle `outValid`=0, `inReady`=1, `opCount`=0, no queued op retires.
- Force `opCount` to 0xFFFF via 65535 LOADA ops, then one more → `opCount`=0x0000, `statusFlags` equal to the last op's flags.

Source files
------------

// File: rtl/ula_stage.sv
// Issue/retire stage around the combinational ula: input FIFO feeding ula,
// registered result with per-opcode flag normalization, status and op counter.
module ula_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAGW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inValid,
  output logic            inReady,
  input  logic [2:0]      inFunc,
  input  logic [31:0]     inA,
  input  logic [31:0]     inB,
  input  logic [TAGW-1:0] inTag,
  output logic [2:0]      func,
  output logic [31:0]     ulaA,
  output logic [31:0]     ulaB,
  input  logic [31:0]     ulaOutput,
  input  logic            ulaZ,
  input  logic            ulaN,
  input  logic            ulaO,
  input  logic            ulaET,
  input  logic            ulaGT,
  input  logic            ulaLT,
  output logic            outValid,
  input  logic            outReady,
  output logic [31:0]     outResult,
  output logic [5:0]      outFlags,
  output logic [TAGW-1:0] outTag,
  output logic [5:0]      statusFlags,
  output logic [15:0]     opCount
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    LOADA = 3'b000,
    ADD   = 3'b001,
    SUB   = 3'b010,
    AND   = 3'b011,
    PLUS1 = 3'b100,
    NOT   = 3'b101,
    XOR   = 3'b110,
    COMP  = 3'b111
  } opCode_e;

  logic [2:0]      fifoFunc [DEPTH];
  logic [31:0]     fifoA    [DEPTH];
  logic [31:0]     fifoB    [DEPTH];
  logic [TAGW-1:0] fifoTag  [DEPTH];

  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic          headValid, push, capture;
  opCode_e       headOp;
  logic [31:0]   normResult;
  logic [5:0]    normFlags;

  // Z and N are derived from the result itself, so ula's own Z/N are not needed.
  logic unusedFlags;
  assign unusedFlags = ulaZ ^ ulaN;

  assign headValid = (count != '0);
  assign inReady   = rst_n && (count < FULL);
  assign push      = inValid && inReady;
  assign capture   = headValid && (!outValid || outReady);

  assign func = headValid ? fifoFunc[rdPtr] : '0;
  assign ulaA = headValid ? fifoA[rdPtr]    : '0;
  assign ulaB = headValid ? fifoB[rdPtr]    : '0;
  assign headOp = opCode_e'(func);

  // ula leaves flags of unrelated opcodes stale, so keep only the meaningful ones.
  always_comb begin
    normResult = ulaOutput;
    normFlags  = {(ulaOutput == '0), ulaOutput[31], 1'b0, 3'b000};
    case (headOp)
      ADD, SUB: normFlags[3] = ulaO;
      COMP: begin
        normResult = '0;
        normFlags  = {3'b000, ulaET, ulaGT, ulaLT};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoFunc[wrPtr] <= inFunc;
      fifoA[wrPtr]    <= inA;
      fifoB[wrPtr]    <= inB;
      fifoTag[wrPtr]  <= inTag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      outValid    <= 1'b0;
      outResult   <= '0;
      outFlags    <= '0;
      outTag      <= '0;
      statusFlags <= '0;
      opCount     <= '0;
    end else begin
      if (push)    wrPtr <= wrPtr + PW'(1);
      if (capture) rdPtr <= rdPtr + PW'(1);
      case ({push, capture})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (capture) begin
        outValid    <= 1'b1;
        outResult   <= normResult;
        outFlags    <= normFlags;
        outTag      <= fifoTag[rdPtr];
        statusFlags <= normFlags;
        opCount     <= opCount + 16'd1;
      end else if (outValid && outReady) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ula_stage.sv
// Randomized and directed bench for ula_stage with a behavioural ula that
// deliberately leaves irrelevant flags/results as junk.
module tb_ula_stage;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAGW  = 4;

  logic            clk, rst_n;
  logic            inValid, inReady;
  logic [2:0]      inFunc;
  logic [31:0]     inA, inB;
  logic [TAGW-1:0] inTag;
  logic [2:0]      func;
  logic [31:0]     ulaA, ulaB, ulaOutput;
  logic            ulaZ, ulaN, ulaO, ulaET, ulaGT, ulaLT;
  logic            outValid, outReady;
  logic [31:0]     outResult;
  logic [5:0]      outFlags, statusFlags;
  logic [TAGW-1:0] outTag;
  logic [15:0]     opCount;

  ula_stage #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .inValid(inValid), .inReady(inReady), .inFunc(inFunc), .inA(inA), .inB(inB), .inTag(inTag),
    .func(func), .ulaA(ulaA), .ulaB(ulaB), .ulaOutput(ulaOutput),
    .ulaZ(ulaZ), .ulaN(ulaN), .ulaO(ulaO), .ulaET(ulaET), .ulaGT(ulaGT), .ulaLT(ulaLT),
    .outValid(outValid), .outReady(outReady), .outResult(outResult), .outFlags(outFlags),
    .outTag(outTag), .statusFlags(statusFlags), .opCount(opCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ula: unrelated outputs carry junk to mimic stale values.
  logic [32:0] wide;
  always_comb begin
    wide      = '0;
    ulaOutput = ulaA ^ 32'hA5C3_0F96;
    ulaZ      = ulaA[2];
    ulaN      = ulaB[7];
    ulaO      = ulaA[0] ^ ulaB[3];
    {ulaET, ulaGT, ulaLT} = {ulaA[1], ulaB[2], ulaA[5]};
    case (func)
      3'd0: ulaOutput = ulaA;
      3'd1: begin
        wide = {ulaA[31], ulaA} + {ulaB[31], ulaB};
        ulaOutput = wide[31:0];
        ulaO = wide[32] ^ wide[31];
      end
      3'd2: begin
        wide = {ulaA[31], ulaA} - {ulaB[31], ulaB};
        ulaOutput = wide[31:0];
        ulaO = wide[32] ^ wide[31];
      end
      3'd3: ulaOutput = ulaA & ulaB;
      3'd4: ulaOutput = ulaA + 32'd1;
      3'd5: ulaOutput = ~ulaA;
      3'd6: ulaOutput = ulaA ^ ulaB;
      default: {ulaET, ulaGT, ulaLT} = {ulaA == ulaB, ulaA > ulaB, ulaA < ulaB};
    endcase
  end

  typedef struct packed {
    logic [31:0]     r;
    logic [5:0]      f;
    logic [TAGW-1:0] t;
  } exp_t;

  exp_t        sbQ[$];
  logic [15:0] accCount;
  logic [5:0]  lastFlags;
  int          assertCount = 0;
  int          failCount   = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t refOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAGW-1:0] t);
    exp_t   e;
    longint s;
    logic   o;
    e.t = t;
    e.r = '0;
    o   = 1'b0;
    s   = 0;
    case (f)
      3'd0: e.r = a;
      3'd1: begin
        e.r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: begin
        e.r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd3: e.r = a & b;
      3'd4: e.r = a + 32'd1;
      3'd5: e.r = ~a;
      3'd6: e.r = a ^ b;
      default: e.r = '0;
    endcase
    if (f == 3'd7) e.f = {3'b000, a == b, a > b, a < b};
    else           e.f = {e.r == 32'd0, e.r[31], o, 3'b000};
    return e;
  endfunction

  // Scoreboard: handshakes are decided at the next rising edge; inputs are stable here.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbQ.delete();
      accCount = '0;
    end else begin
      if (outValid && outReady) begin
        if (sbQ.size() == 0) checkVal("sbEmpty", 64'(outValid), 64'd0);
        else begin
          e = sbQ.pop_front();
          checkVal("result", 64'(outResult), 64'(e.r));
          checkVal("flags",  64'(outFlags),  64'(e.f));
          checkVal("tag",    64'(outTag),    64'(e.t));
          lastFlags = e.f;
        end
      end
      if (inValid && inReady) begin
        sbQ.push_back(refOp(inFunc, inA, inB, inTag));
        accCount = accCount + 16'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAGW-1:0] t);
    logic acc;
    int   n;
    inValid = 1'b1; inFunc = f; inA = a; inB = b; inTag = t;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      acc = inReady;
      tick();
      n++;
      if (!acc && n > 200) begin
        checkVal("sendTimeout", 64'(inReady), 64'd1);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    inValid  = 1'b0;
    outReady = 1'b1;
    n = 0;
    while ((sbQ.size() != 0 || outValid) && n < 200) begin
      tick();
      n++;
    end
    checkVal("drain", 64'((sbQ.size() == 0) && !outValid), 64'd1);
  endtask

  logic [2:0]  bpF [4];
  logic [31:0] bpA [4];
  logic [31:0] bpB [4];

  initial begin
    #1500000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    logic        held;
    int          validCycles, firstC, lastC;
    logic [15:0] n;
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inFunc = '0; inA = '0; inB = '0; inTag = '0; lastFlags = '0;
    repeat (3) tick();
    checkVal("rstInReady", 64'(inReady), 64'd0);
    checkVal("rstOutValid", 64'(outValid), 64'd0);
    rst_n = 1'b1;
    #1;
    checkVal("postRstInReady", 64'(inReady), 64'd1);
    checkVal("postRstOpCount", 64'(opCount), 64'd0);
    checkVal("postRstStatus", 64'(statusFlags), 64'd0);
    checkVal("postRstResult", 64'(outResult), 64'd0);
    checkVal("emptyUlaDrive", 64'({func, ulaA, ulaB}), 64'd0);

    // Two-edge latency with signed overflow
    outReady = 1'b1;
    sendOp(3'd1, 32'h7FFF_FFFF, 32'd1, 4'd3);
    inValid = 1'b0;
    checkVal("latNotYet", 64'(outValid), 64'd0);
    checkVal("latFunc", 64'(func), 64'd1);
    checkVal("latUlaA", 64'(ulaA), 64'h7FFF_FFFF);
    tick();
    checkVal("latValid", 64'(outValid), 64'd1);
    checkVal("latResult", 64'(outResult), 64'h8000_0000);
    checkVal("latFlags", 64'(outFlags), 64'b011000);
    checkVal("latTag", 64'(outTag), 64'd3);
    checkVal("latOpCount", 64'(opCount), 64'd1);

    // SUB to zero followed by COMP: no stale Z/O on COMP
    sendOp(3'd2, 32'd5, 32'd5, 4'd1);
    sendOp(3'd7, 32'd5, 32'd9, 4'd2);
    drain();
    checkVal("compStatus", 64'(statusFlags), 64'b000001);
    checkVal("compOpCount", 64'(opCount), 64'(accCount));

    // Backpressure: DEPTH+1 accepted, next one blocked, head held stable
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bpF[i] = 3'($urandom_range(0, 7));
      bpA[i] = $urandom();
      bpB[i] = $urandom();
    end
    for (int i = 0; i < 3; i++) sendOp(bpF[i], bpA[i], bpB[i], 4'(4 + i));
    inValid = 1'b1; inFunc = bpF[3]; inA = bpA[3]; inB = bpB[3]; inTag = 4'd7;
    repeat (3) tick();
    checkVal("bpInReady", 64'(inReady), 64'd0);
    checkVal("bpOutValid", 64'(outValid), 64'd1);
    checkVal("bpHeldTag", 64'(outTag), 64'd4);
    checkVal("bpHeadFunc", 64'(func), 64'(bpF[1]));
    checkVal("bpHeadA", 64'(ulaA), 64'(bpA[1]));
    outReady = 1'b1;
    sendOp(bpF[3], bpA[3], bpB[3], 4'd7);
    drain();

    // Back-to-back PLUS1 stream: one result per cycle
    validCycles = 0; firstC = -1; lastC = -1;
    fork
      begin
        for (int i = 0; i < 8; i++) sendOp(3'd4, 32'hFFFF_FFFF - 32'(i), $urandom(), 4'(i));
        inValid = 1'b0;
      end
      begin
        for (int c = 0; c < 14; c++) begin
          tick();
          if (outValid) begin
            validCycles++;
            if (firstC < 0) firstC = c;
            lastC = c;
          end
        end
      end
    join
    checkVal("streamCount", 64'(validCycles), 64'd8);
    checkVal("streamSpan", 64'(lastC - firstC), 64'd7);
    drain();

    // Reset with work in flight: nothing replays
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) sendOp(3'd6, $urandom(), $urandom(), 4'(9 + i));
    inValid = 1'b0;
    tick();
    checkVal("preRstValid", 64'(outValid), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checkVal("midRstValid", 64'(outValid), 64'd0);
    checkVal("midRstInReady", 64'(inReady), 64'd1);
    checkVal("midRstOpCount", 64'(opCount), 64'd0);
    checkVal("midRstTag", 64'(outTag), 64'd0);
    outReady = 1'b1;
    repeat (5) tick();
    checkVal("noReplay", 64'(outValid), 64'd0);

    // Random traffic with random backpressure
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        inValid = ($urandom_range(0, 3) != 0);
        inFunc  = 3'($urandom_range(0, 7));
        inA     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        inB     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        inTag   = 4'($urandom());
      end
      outReady = ($urandom_range(0, 3) != 0);
      held = inValid && !inReady;
      tick();
    end
    drain();
    checkVal("randOpCount", 64'(opCount), 64'(accCount));
    checkVal("randStatus", 64'(statusFlags), 64'(lastFlags));

    // Counter wrap
    n = 16'hFFFF - accCount;
    for (int i = 0; i < int'(n); i++) sendOp(3'd0, 32'(i + 1), '0, 4'(i));
    drain();
    checkVal("wrapPre", 64'(opCount), 64'hFFFF);
    sendOp(3'd0, 32'd0, $urandom(), 4'd5);
    drain();
    checkVal("wrapPost", 64'(opCount), 64'd0);
    checkVal("wrapStatus", 64'(statusFlags), 64'(lastFlags));
    checkVal("wrapStatusZ", 64'(statusFlags), 64'b100000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
